// File: rtl/pc_control.sv
// pc_control: program counter and condition-flag unit for the single-cycle core.
//
// It holds the PC register, the {Z,V,N} flag register and the RUN/HALTED state.
// It resolves B and BR branches against the registered flags. It also produces
// PC+2, which is the fetch fall-through value and the write data for PCS.
//
// Ports
//   clk      in   core clock; all state updates happen on the rising edge
//   rst      in   asynchronous, active-high reset
//   Instr    in   [15:12] opcode, [11:9] condition, [8:0] B immediate
//   RegData  in   rs read value, used as the BR target
//   AluZ/V/N in   ALU flags for the current instruction
//   Stall    in   hold every register this cycle
//   PC       out  registered fetch address
//   PCPlus2  out  PC + 2, mod 2^16
//   Taken    out  combinational branch-taken for B/BR
//   Flags    out  registered {Z,V,N}
//   Halted   out  1 while in the HALTED state
module pc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instr,
    input  logic [15:0] RegData,
    input  logic        AluZ,
    input  logic        AluV,
    input  logic        AluN,
    input  logic        Stall,
    output logic [15:0] PC,
    output logic [15:0] PCPlus2,
    output logic        Taken,
    output logic [2:0]  Flags,
    output logic        Halted
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, state_nx;
    logic [15:0] pc_q, pc_nx;
    logic [2:0]  flags_q, flags_nx;   // {Z,V,N}
    logic [3:0]  opcode;
    logic [2:0]  cond;
    logic        fz, fv, fn;
    logic        cond_true;
    logic [15:0] boff;

    assign opcode = Instr[15:12];
    assign cond   = Instr[11:9];
    assign {fz, fv, fn} = flags_q;

    // The 9-bit word offset is sign-extended and turned into a byte offset.
    assign boff = {{6{Instr[8]}}, Instr[8:0], 1'b0};

    assign PC      = pc_q;
    assign PCPlus2 = pc_q + 16'd2;
    assign Flags   = flags_q;
    assign Halted  = (state == HALTED);

    // Conditions read the registered flags. That is how a flag write from the
    // previous instruction reaches this branch without a bubble.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000: cond_true = !fz;
            3'b001: cond_true = fz;
            3'b010: cond_true = !fz && !fn;
            3'b011: cond_true = fn;
            3'b100: cond_true = fz || (!fz && !fn);
            3'b101: cond_true = fn || fz;
            3'b110: cond_true = fv;
            default: cond_true = 1'b1;
        endcase
    end

    assign Taken = (state == RUN) && ((opcode == OP_B) || (opcode == OP_BR)) && cond_true;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pc_q    <= 16'h0000;
            flags_q <= 3'b000;
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            flags_q <= flags_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        flags_nx = flags_q;
        if (state == RUN && !Stall) begin
            // Next PC
            if (opcode == OP_B && Taken)
                pc_nx = PCPlus2 + boff;
            else if (opcode == OP_BR && Taken)
                pc_nx = RegData;
            else if (opcode == OP_HLT)
                pc_nx = pc_q;
            else
                pc_nx = PCPlus2;

            // Flag write mask by opcode
            case (opcode)
                OP_ADD, OP_SUB:                 flags_nx = {AluZ, AluV, AluN};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_nx = {AluZ, flags_q[1:0]};
                default:                        flags_nx = flags_q;
            endcase

            if (opcode == OP_HLT)
                state_nx = HALTED;
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control. It applies a table of instruction vectors with
// expected results. It also runs hand-written sequences for an asynchronous
// reset during halt and during stall.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Instr, RegData;
    logic        AluZ, AluV, AluN, Stall;
    logic [15:0] PC, PCPlus2;
    logic        Taken, Halted;
    logic [2:0]  Flags;

    pc_control dut (
        .clk(clk), .rst(rst), .Instr(Instr), .RegData(RegData),
        .AluZ(AluZ), .AluV(AluV), .AluN(AluN), .Stall(Stall),
        .PC(PC), .PCPlus2(PCPlus2), .Taken(Taken), .Flags(Flags), .Halted(Halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rd;
        logic [2:0]  alu;
        logic        stall;
        logic        taken;
        logic [15:0] pc;
        logic [2:0]  flags;
        logic        halted;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  flags;
        logic        halted;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cur_pc;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] c, input logic [8:0] imm);
        return {op, c, imm};
    endfunction

    function automatic vec_t mk(input logic [15:0] i, input logic [15:0] rd, input logic [2:0] alu,
                                input logic st, input logic tk, input logic [15:0] pc,
                                input logic [2:0] fl, input logic h);
        vec_t v;
        v.instr = i; v.rd = rd; v.alu = alu; v.stall = st;
        v.taken = tk; v.pc = pc; v.flags = fl; v.halted = h;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    // Drive one instruction, then check the combinational outputs. The expected
    // post-edge state goes onto the scoreboard and is compared after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        Instr = v.instr; RegData = v.rd; {AluZ, AluV, AluN} = v.alu; Stall = v.stall;
        #2;
        chk("taken", idx, {15'd0, Taken}, {15'd0, v.taken});
        chk("pcplus2", idx, PCPlus2, cur_pc + 16'd2);
        e.pc = v.pc; e.flags = v.flags; e.halted = v.halted;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("pc", idx, PC, e.pc);
        chk("flags", idx, {13'd0, Flags}, {13'd0, e.flags});
        chk("halted", idx, {15'd0, Halted}, {15'd0, e.halted});
        cur_pc = e.pc;
    endtask

    initial begin
        //              instr                rd       alu     st    tk    pc        fl      h
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0002, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0004, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0006, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd7,9'h0),  16'h0010, 3'b000, 1'b0, 1'b1, 16'h0010, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b100, 1'b0, 1'b0, 16'h0012, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd1,9'h1FF),16'h0, 3'b000, 1'b0, 1'b1, 16'h0012, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd0,9'h1FF),16'h0, 3'b000, 1'b0, 1'b0, 16'h0014, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b111, 1'b0, 1'b0, 16'h0016, 3'b111, 1'b0));
        tbl.push_back(mk(ins(4'h2,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0018, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'h8,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h001A, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd6,9'h004),16'h0, 3'b000, 1'b0, 1'b1, 16'h0024, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd2,9'h005),16'h0, 3'b000, 1'b0, 1'b0, 16'h0026, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd3,9'h1FD),16'h0, 3'b000, 1'b0, 1'b1, 16'h0022, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd5,9'h000),16'h0, 3'b000, 1'b0, 1'b1, 16'h0024, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd4,9'h000),16'h0, 3'b000, 1'b0, 1'b0, 16'h0026, 3'b011, 1'b0));
        tbl.push_back(mk(ins(4'h1,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0028, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd4,9'h000),16'h0, 3'b000, 1'b0, 1'b1, 16'h002A, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'h4,3'd0,9'h0),  16'h0, 3'b111, 1'b0, 1'b0, 16'h002C, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b111, 1'b1, 1'b0, 16'h002C, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hE,3'd7,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h002E, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd7,9'h0),  16'h0100, 3'b000, 1'b0, 1'b1, 16'h0100, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd7,9'h0),  16'hABCD, 3'b000, 1'b0, 1'b1, 16'hABCD, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd7,9'h0),  16'hFFFE, 3'b000, 1'b0, 1'b1, 16'hFFFE, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hE,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd0,9'h0),  16'h1234, 3'b000, 1'b0, 1'b0, 16'h0002, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd7,9'h0),  16'hFFF0, 3'b000, 1'b0, 1'b1, 16'hFFF0, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hC,3'd7,9'h010),16'h0, 3'b000, 1'b0, 1'b1, 16'h0012, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'h5,3'd0,9'h0),  16'h0, 3'b011, 1'b0, 1'b0, 16'h0014, 3'b000, 1'b0));
        tbl.push_back(mk(ins(4'h6,3'd0,9'h0),  16'h0, 3'b100, 1'b0, 1'b0, 16'h0016, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'h3,3'd0,9'h0),  16'h0, 3'b011, 1'b0, 1'b0, 16'h0018, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hD,3'd7,9'h0),  16'h0020, 3'b000, 1'b0, 1'b1, 16'h0020, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hF,3'd0,9'h0),  16'h0, 3'b000, 1'b1, 1'b0, 16'h0020, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hF,3'd0,9'h0),  16'h0, 3'b000, 1'b1, 1'b0, 16'h0020, 3'b100, 1'b0));
        tbl.push_back(mk(ins(4'hF,3'd0,9'h0),  16'h0, 3'b000, 1'b0, 1'b0, 16'h0020, 3'b100, 1'b1));
        tbl.push_back(mk(ins(4'hC,3'd7,9'h010),16'h0, 3'b000, 1'b0, 1'b0, 16'h0020, 3'b100, 1'b1));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b011, 1'b0, 1'b0, 16'h0020, 3'b100, 1'b1));
        tbl.push_back(mk(ins(4'h0,3'd0,9'h0),  16'h0, 3'b011, 1'b1, 1'b0, 16'h0020, 3'b100, 1'b1));

        rst = 1'b1; Instr = 16'h0; RegData = 16'h0; AluZ = 0; AluV = 0; AluN = 0; Stall = 0;
        #1;
        chk("rst_pc", 0, PC, 16'h0000);
        chk("rst_flags", 0, {13'd0, Flags}, 16'h0000);
        chk("rst_halted", 0, {15'd0, Halted}, 16'h0000);
        chk("rst_pcplus2", 0, PCPlus2, 16'h0002);
        chk("rst_taken", 0, {15'd0, Taken}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        cur_pc = 16'h0000;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], i);

        // Asynchronous reset between edges while halted
        #2 rst = 1'b1;
        #1;
        chk("async_halt_pc", 100, PC, 16'h0000);
        chk("async_halt_flags", 100, {13'd0, Flags}, 16'h0000);
        chk("async_halt_halted", 100, {15'd0, Halted}, 16'h0000);
        chk("async_halt_pcplus2", 100, PCPlus2, 16'h0002);
        @(posedge clk); #1;
        rst = 1'b0;
        cur_pc = 16'h0000;
        step(mk(ins(4'h0,3'd0,9'h0), 16'h0, 3'b101, 1'b0, 1'b0, 16'h0002, 3'b101, 1'b0), 101);
        step(mk(ins(4'h0,3'd0,9'h0), 16'h0, 3'b000, 1'b0, 1'b0, 16'h0004, 3'b000, 1'b0), 102);

        // Asynchronous reset in the middle of a stall
        Instr = ins(4'h0,3'd0,9'h0); {AluZ, AluV, AluN} = 3'b111; Stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_stall_pc", 103, PC, 16'h0000);
        chk("async_stall_flags", 103, {13'd0, Flags}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("async_stall_hold_pc", 104, PC, 16'h0000);
        cur_pc = 16'h0000;
        step(mk(ins(4'hF,3'd0,9'h0), 16'h0, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b1), 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter and condition-flag unit for the single-cycle core. It consumes the same 4-bit opcode the control decoder drives from, plus ALU flag outputs, and produces the instruction-fetch address. It owns the PC register, the Z/V/N flag register, branch resolution for B/BR, the PC+2 value used by PCS, and the sticky halt state entered on HLT.

## Interface
- No parameters; data width fixed at 16, branch immediate fixed at 9 bits.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Instr  in  16  current instruction; [15:12] opcode, [11:9] condition, [8:0] B immediate.
- RegData  in  16  rs read-port value, the BR target.
- AluZ, AluV, AluN  in  1 each  ALU zero/overflow/negative for the current instruction.
- Stall  in  1  hold: no PC, flag or state update this cycle.
- PC  out  16  registered fetch address.
- PCPlus2  out  16  PC + 2 mod 2^16, write data for PCS.
- Taken  out  1  combinational: current B/BR condition is true.
- Flags  out  3  registered {Z,V,N}.
- Halted  out  1  registered; 1 in HALTED state.

## Operation
- States: RUN, HALTED. rst -> RUN. RUN + opcode 0xF + !Stall -> HALTED at the edge. HALTED is sticky; only rst leaves it.
- Next PC in RUN (taken when !Stall):
  - opcode 0xC with Taken: PCPlus2 + (sext(Instr[8:0]) << 1), mod 2^16.
  - opcode 0xD with Taken: RegData (bit 0 passed through unmodified).
  - opcode 0xF: PC (holds on the HLT address).
  - otherwise: PCPlus2.
- Conditions, evaluated on registered Flags, not ALU flags:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | (!Z & !N)
  - 101 LTE: N | Z
  - 110 OV: V
  - 111: always
- Taken is 0 for any opcode other than 0xC/0xD, and 0 while HALTED.
- Flag update (RUN, !Stall only):
  - 0x0 ADD, 0x1 SUB: Z, V and N all load from the ALU.
  - 0x2 XOR, 0x4 SLL, 0x5 SRA, 0x6 ROR: load Z only; V and N hold.
  - All other opcodes, including RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS and HLT, hold all flags.
- HALTED: PC, Flags hold regardless of Instr and Stall.

## Timing
- Reset values: PC=0x0000, Flags=000, Halted=0, state RUN. Reset is asserted immediately, independent of clk. Taken and PCPlus2 follow combinationally (PCPlus2=0x0002).
- Latency:
  - Next PC is visible on PC one cycle after the instruction is presented. Branch resolution is zero-bubble.
  - A flag write from instruction N is visible to a branch at N+1.
- Stall=1: all registers hold. An HLT under Stall does not halt until the first non-stalled cycle.
- Wrap-around:
  - PC=0xFFFE, non-branch -> PC=0x0000.
  - Branch target arithmetic wraps modulo 2^16.
- rst mid-halt or mid-stall: immediate return to reset values.

## Test plan
- Reset, then 3 non-branch instructions (opcode 0x0) with ALU flags 0 -> PC 0x0000, 0x0002, 0x0004, 0x0006; Halted=0; PCPlus2 tracks PC+2.
- ADD with AluZ=1 at PC=0x0010, then B cond=001 imm=0x1FF at 0x0012 -> Flags=100, Taken=1, PC=0x0012 (self-loop). Repeat with cond=000 -> Taken=0, PC=0x0014.
- Flag masking, after ADD sets Z,V,N=1,1,1:
  - XOR with AluZ=0, AluV=0, AluN=0 -> Flags=011.
  - LW with all ALU flags 0 -> Flags stay 011.
  - B cond=110 -> taken.
- BR cond=111, RegData=0xABCD at PC=0x0100 -> next PC=0xABCD. PCS at PC=0xFFFE -> PCPlus2=0x0000, next PC=0x0000.
- Stall=1 for 2 cycles with HLT presented at PC=0x0020 -> PC stays 0x0020, Halted=0. Then Stall=0 -> Halted=1, PC=0x0020; subsequent B cond=111 -> Taken=0, PC unchanged.
- Assert rst asynchronously between edges while Halted=1 -> Halted=0, PC=0x0000, Flags=000 before next edge.
